seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_pkg.sv | 26 ++
 rtl/seq_edge_mealy.sv | 36 +++
 rtl/seq_detect_ctrl.sv | 110 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial transition-count controller.
package seq_pkg;

    localparam int unsigned TOTAL_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        D_INIT = 2'd0,
        D_LOW  = 2'd1,
        D_HIGH = 2'd2
    } det_state_e;

    // Unsigned add that clamps at all-ones instead of wrapping.
    function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                   input logic [TOTAL_W-1:0] b);
        logic [TOTAL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
    endfunction

endpackage

// File: rtl/seq_edge_mealy.sv
// Mealy bit-transition detector: flags each bit that differs from the previous one.
module seq_edge_mealy
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic det
);

    det_state_e state_q;
    det_state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= D_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // D_INIT holds no history, so the first bit of a word never flags.
    always_comb begin
        state_d = state_q;
        det     = en && (((state_q == D_LOW) && bit_in) ||
                         ((state_q == D_HIGH) && !bit_in));
        if (clr) begin
            state_d = D_INIT;
        end else if (en) begin
            state_d = bit_in ? D_HIGH : D_LOW;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Accepts a parallel word, scans it LSB first through the transition detector,
// reports the per-word count and keeps a saturating running total.
module seq_detect_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [CNT_W-1:0]   out_count,
    input  logic               out_ready,
    output logic               busy,
    output logic [TOTAL_W-1:0] total_count
);

    localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    ctrl_state_e        state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               in_ready_q, out_valid_q, busy_q;
    logic               det_clr, det_en, det;

    seq_edge_mealy u_det (
        .clk    (clk),
        .rst    (rst),
        .clr    (det_clr),
        .en     (det_en),
        .bit_in (shreg_q[0]),
        .det    (det)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        det_clr = 1'b0;
        det_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    idx_d   = '0;
                    cnt_d   = '0;
                    det_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                det_en  = 1'b1;
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + IDX_W'(1);
                if (det) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    total_d = sat_add(total_q, TOTAL_W'(cnt_q));
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they align with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            total_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == REPORT);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_count   = cnt_q;
    assign total_count = total_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: word-level reference model plus directed
// and random stimulus; a WIDTH=32 instance exercises total_count saturation quickly.
module tb_seq_detect_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned W32   = 32;
    localparam int unsigned C32   = 6;

    logic             clk = 1'b0;
    logic             rst, in_valid, out_ready, in_ready, out_valid, busy;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] out_count;
    logic [15:0]      total_count;

    logic             rst32, in_valid32, out_ready32, in_ready32, out_valid32, busy32;
    logic [W32-1:0]   in_data32;
    logic [C32-1:0]   out_count32;
    logic [15:0]      total_count32;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_count(out_count),
        .out_ready(out_ready), .busy(busy), .total_count(total_count)
    );

    seq_detect_ctrl #(.WIDTH(W32)) dut32 (
        .clk(clk), .rst(rst32), .in_valid(in_valid32), .in_data(in_data32),
        .in_ready(in_ready32), .out_valid(out_valid32), .out_count(out_count32),
        .out_ready(out_ready32), .busy(busy32), .total_count(total_count32)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: transitions = number of adjacent bit pairs that differ.
    function automatic int unsigned transitions(input logic [WIDTH-1:0] w);
        int unsigned n = 0;
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            if (w[i] != w[i+1]) n++;
        end
        return n;
    endfunction

    // Word-level model: an accepted word reports WIDTH+1 cycles after its accept cycle.
    int unsigned cyc     = 0;
    bit          m_valid = 1'b0;
    bit          pend    = 1'b0;
    int unsigned acc     = 0;
    int unsigned m_cnt   = 0;
    int unsigned m_total = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            pend    = 1'b0;
            m_total = 0;
        end else if (m_valid) begin
            if (!pend) begin
                if (in_valid) begin
                    pend  = 1'b1;
                    acc   = cyc;
                    m_cnt = transitions(in_data);
                end
            end else if (cyc >= acc + WIDTH + 1 && out_ready) begin
                m_total = (m_total + m_cnt > 65535) ? 65535 : m_total + m_cnt;
                pend    = 1'b0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            bit rep;
            rep = pend && (cyc >= acc + WIDTH + 1);
            chk("in_ready", 32'(in_ready), 32'(!pend));
            chk("busy", 32'(busy), 32'(pend));
            chk("out_valid", 32'(out_valid), 32'(rep));
            if (rep) chk("out_count", 32'(out_count), m_cnt);
            chk("total_count", 32'(total_count), m_total);
        end
    end

    task automatic offer(input logic [WIDTH-1:0] d, output bit ok);
        in_valid = 1'b1;
        in_data  = d;
        ok       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic run_word(input logic [WIDTH-1:0] d, input int unsigned exp,
                            input int hold, input bit ff_during);
        bit ok;
        int lat;
        out_ready = (hold == 0);
        offer(d, ok);
        if (ok) begin
            if (ff_during) begin
                in_valid = 1'b1;
                in_data  = 8'hFF;
            end
            lat = 0;
            for (int k = 1; k <= 40; k++) begin
                if (out_valid) begin
                    lat = k;
                    break;
                end
                if (ff_during) chk("in_ready_shift", 32'(in_ready), 32'd0);
                @(negedge clk);
            end
            chk("latency", 32'(lat), 32'd9);
            for (int h = 0; h < hold; h++) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_count", 32'(out_count), exp);
                chk("hold_in_ready", 32'(in_ready), 32'd0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            chk("word_count", 32'(out_count), exp);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic main_seq();
        bit ok;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_total", 32'(total_count), 32'd0);
        rst = 1'b0;

        run_word(8'h00, 0, 0, 1'b0);
        run_word(8'hFF, 0, 0, 1'b0);
        chk("total_zero", 32'(total_count), 32'd0);
        run_word(8'h55, 7, 0, 1'b0);
        run_word(8'h0F, 1, 0, 1'b0);
        run_word(8'h80, 1, 0, 1'b0);
        chk("total_nine", 32'(total_count), 32'd9);
        run_word(8'h55, 7, 5, 1'b1);
        run_word(8'hFF, 0, 0, 1'b0);
        chk("total_sixteen", 32'(total_count), 32'd16);

        // Reset lands on the edge closing the 4th shift cycle.
        offer(8'h55, ok);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_total", 32'(total_count), 32'd0);
        run_word(8'h0F, 1, 0, 1'b0);
        chk("after_rst_total", 32'(total_count), 32'd1);

        repeat (800) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = WIDTH'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // 0x55555555 gives 31 transitions; 2114*31 = 0xFFFE, one more word saturates.
    task automatic sat_seq();
        int unsigned exp;
        bit found;
        rst32 = 1'b1; in_valid32 = 1'b0; out_ready32 = 1'b1; in_data32 = 32'h5555_5555;
        repeat (2) @(negedge clk);
        chk("rst32_total", 32'(total_count32), 32'd0);
        rst32 = 1'b0;
        in_valid32 = 1'b1;
        for (int n = 1; n <= 2116; n++) begin
            found = 1'b0;
            for (int k = 0; k < 60; k++) begin
                if (out_valid32) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!found) begin
                chk("sat_report_timeout", 32'd0, 32'd1);
                break;
            end
            chk("sat_word_count", 32'(out_count32), 32'd31);
            @(negedge clk);
            exp = (n * 31 > 65535) ? 65535 : n * 31;
            chk("sat_total", 32'(total_count32), exp);
            if (n == 2114) chk("sat_fffe", 32'(total_count32), 32'h0000_FFFE);
            if (n >= 2115) chk("sat_ffff", 32'(total_count32), 32'h0000_FFFF);
        end
        in_valid32 = 1'b0;
    endtask

    initial begin
        fork
            main_seq();
            sat_seq();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
